misc_sequencer: RTL and testbench
=================================

# misc_sequencer

Multi-cycle instruction sequencer for the MISC-V core. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK using the decoded control lines from `Control`. Arbitrates the single memory port between instruction fetch and data access with a req/ready handshake. Emits the per-phase enables (IR load, PC increment/load, register write) that gate the datapath.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter.

- `CLK`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  permits starting a new fetch; sampled only in FETCH.
- `opcode`  in  3  opcode field of the instruction register.
- `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `JumpOut`  in  1 each  decoded lines from `Control`.
- `zero`  in  1  ALU zero flag, valid in EXECUTE.
- `mem_ready`  in  1  memory completes the outstanding request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `mem_ifetch`  out  1  high when the request is an instruction fetch (selects the PC as address).
- `ir_write`  out  1  load the instruction register.
- `pc_inc`  out  1  PC <= PC + 1.
- `pc_load`  out  1  PC <= branch/jump target. Never high in the same cycle as `pc_inc`.
- `reg_we`  out  1  register-file write enable.
- `retire`  out  1  one-cycle pulse on the final cycle of each instruction.
- `busy`  out  1  high in every state except FETCH with no request pending.
- `state`  out  3  current state encoding.
- `instr_count`  out  CNT_W  retired-instruction count. Wraps from all-ones to 0.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4. Codes 5–7 are illegal and go to FETCH on the next edge.
- Internal flag `pending` holds a request in flight. `mem_req` = `pending` | (state ∈ {FETCH, MEMORY} & request-start condition).
- FETCH:
  - If `run` = 1 or `pending` = 1: assert `mem_req` with `mem_ifetch` = 1 and `mem_we` = 0.
  - On `mem_ready`: pulse `ir_write` and `pc_inc`, clear `pending`, go to DECODE.
  - Without `mem_ready`: set `pending` and stay in FETCH.
- DECODE: one cycle, no outputs active. Go to EXECUTE.
- EXECUTE (one cycle):
  - If `MemRead` | `MemWrite`: go to MEMORY.
  - Else if `Branch`: `pc_load` = taken, `retire` = 1, go to FETCH.
    - Taken rules: opcode 4 → `zero`; opcode 5 → !`zero`; opcodes 6 and 7 → 1.
  - Else if `RegWrite`: go to WRITEBACK.
  - Else: `retire` = 1, go to FETCH.
- MEMORY:
  - Assert `mem_req` with `mem_we` = `MemWrite` and `mem_ifetch` = 0. Hold it until `mem_ready`.
  - On `mem_ready`: if `MemRead`, go to WRITEBACK; otherwise pulse `retire` and go to FETCH.
- WRITEBACK: `reg_we` = 1 and `retire` = 1 for one cycle. Go to FETCH.
- `instr_count` increments on every cycle where `retire` = 1.
- Handshake rules:
  - Once `mem_req` is high it stays high, with unchanged `mem_we` and `mem_ifetch`, until the cycle `mem_ready` is sampled high.
  - `mem_ready` is ignored while `mem_req` = 0.
  - Completion in the same cycle the request first rises is legal (zero-wait memory).
- `run` falling while a fetch is pending does not withdraw the request. The fetch completes and the instruction runs to retirement. The next fetch is withheld until `run` = 1.
- `Control` inputs are treated as stable from DECODE through instruction retirement.

## Timing
- Reset asserted (asynchronous, immediate):
  - state = FETCH, `pending` = 0, `instr_count` = 0.
  - All outputs are 0, including `mem_req` (gated by reset), `busy` and `retire`.
- Reset released: the first request can rise in the same cycle if `run` = 1.
- `ir_write`, `pc_inc`, `pc_load`, `reg_we` and `retire` are combinational from state and inputs. All state, `pending` and `instr_count` are registered.
- Cycles per instruction with zero-wait memory:
  - R/I-type: 4.
  - LW: 5.
  - SW: 4.
  - Branch, taken or not: 3.
  - Jump (opcodes 6/7): 3.
  - Each wait cycle on `mem_ready` adds 1.
- Reset asserted mid-MEMORY or mid-FETCH: the request drops in the same cycle and no `retire` is produced for the aborted instruction.

## Test plan
- Reset with `run` = 1, R-type add (opcode 0), `mem_ready` tied 1 → `ir_write` in cycle 0, `reg_we` and `retire` in cycle 3, `instr_count` = 1, next `mem_req` with `mem_ifetch` in cycle 4.
- LW (opcode 2) with `mem_ready` low for 2 cycles in MEMORY → `mem_req` = 1 and `mem_we` = 0 held for 3 cycles, then WRITEBACK with `reg_we` = 1. Total 7 cycles.
- Opcode 4 with `zero` = 1, then opcode 4 with `zero` = 0 → first: `pc_load` = 1 in EXECUTE. Second: `pc_load` = 0. Both retire in cycle 2.
- Opcode 5 with `zero` = 0, then opcode 7 with any `zero` → `pc_load` = 1 in EXECUTE for both, `reg_we` never high.
- Drop `run` while fetch is pending (`mem_ready` = 0) → `mem_req` stays high. After `mem_ready`, the instruction retires, then FETCH idles with `mem_req` = 0 and `busy` = 0 until `run` = 1.
- Assert `reset` low in MEMORY of SW → `mem_req` = 0 immediately, state = 0, `instr_count` = 0. Preload `instr_count` at 0xFFFF and retire once → count = 0x0000.

Source files
------------

// File: rtl/misc_sequencer.sv
// misc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
// for the MISC-V core. It arbitrates one memory port between instruction
// fetch and data access, and generates the per-phase datapath enables.
module misc_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             Branch,
  input  logic             JumpOut,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_ifetch,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             reg_we,
  output logic             retire,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  state_t cur, nxt;
  logic   pending, pending_n;
  logic   req, we, ifetch, ir_c, inc_c, load_c, rw_c, ret_c;
  logic   taken;

  // Branch/jump outcome from the opcode field and the ALU zero flag
  always_comb begin
    taken = 1'b0;
    case (opcode)
      3'd4:       taken = zero;
      3'd5:       taken = ~zero;
      3'd6, 3'd7: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

  // Next-state, request and datapath-enable decode
  always_comb begin
    nxt       = cur;
    pending_n = pending;
    req       = 1'b0;
    we        = 1'b0;
    ifetch    = 1'b0;
    ir_c      = 1'b0;
    inc_c     = 1'b0;
    load_c    = 1'b0;
    rw_c      = 1'b0;
    ret_c     = 1'b0;
    case (cur)
      S_FETCH: begin
        // A pending fetch stays asserted even after run drops
        if (run || pending) begin
          req    = 1'b1;
          ifetch = 1'b1;
          if (mem_ready) begin
            ir_c      = 1'b1;
            inc_c     = 1'b1;
            pending_n = 1'b0;
            nxt       = S_DECODE;
          end else begin
            pending_n = 1'b1;
          end
        end
      end
      S_DECODE: nxt = S_EXECUTE;
      S_EXECUTE: begin
        if (MemRead || MemWrite) begin
          nxt = S_MEMORY;
        end else if (Branch || JumpOut) begin
          load_c = taken;
          ret_c  = 1'b1;
          nxt    = S_FETCH;
        end else if (RegWrite) begin
          nxt = S_WRITEBACK;
        end else begin
          ret_c = 1'b1;
          nxt   = S_FETCH;
        end
      end
      S_MEMORY: begin
        req = 1'b1;
        we  = MemWrite;
        if (mem_ready) begin
          if (MemRead) begin
            nxt = S_WRITEBACK;
          end else begin
            ret_c = 1'b1;
            nxt   = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        rw_c  = 1'b1;
        ret_c = 1'b1;
        nxt   = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // State, pending flag and retired-instruction counter
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cur         <= S_FETCH;
      pending     <= 1'b0;
      instr_count <= '0;
    end else begin
      cur         <= nxt;
      pending     <= pending_n;
      instr_count <= instr_count + CNT_W'(ret_c);
    end
  end

  // Combinational outputs are forced low while reset is held so an aborted
  // request drops immediately rather than at the next edge.
  assign mem_req    = reset & req;
  assign mem_we     = reset & we;
  assign mem_ifetch = reset & ifetch;
  assign ir_write   = reset & ir_c;
  assign pc_inc     = reset & inc_c;
  assign pc_load    = reset & load_c;
  assign reg_we     = reset & rw_c;
  assign retire     = reset & ret_c;
  assign busy       = reset & ((cur != S_FETCH) | req);
  assign state      = cur;

endmodule

// File: tb/tb_misc_sequencer.sv
// Directed self-checking bench for misc_sequencer. A second instance with a
// narrow counter exercises the instr_count wrap.
module tb_misc_sequencer;

  logic        CLK, reset, run, RegWrite, MemRead, MemWrite, Branch, JumpOut, zero, mem_ready;
  logic [2:0]  opcode;
  logic        mem_req, mem_we, mem_ifetch, ir_write, pc_inc, pc_load, reg_we, retire, busy;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic        mem_req2, mem_we2, mem_ifetch2, ir_write2, pc_inc2, pc_load2, reg_we2, retire2, busy2;
  logic [2:0]  state2;
  logic [2:0]  instr_count2;

  int checks = 0;
  int errors = 0;

  misc_sequencer #(.CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .run(run), .opcode(opcode),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .JumpOut(JumpOut), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ifetch(mem_ifetch),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we),
    .retire(retire), .busy(busy), .state(state), .instr_count(instr_count)
  );

  misc_sequencer #(.CNT_W(3)) dut_w (
    .CLK(CLK), .reset(reset), .run(run), .opcode(opcode),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .JumpOut(JumpOut), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_ifetch(mem_ifetch2),
    .ir_write(ir_write2), .pc_inc(pc_inc2), .pc_load(pc_load2), .reg_we(reg_we2),
    .retire(retire2), .busy(busy2), .state(state2), .instr_count(instr_count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ctrl(input logic [2:0] op, input logic rw, input logic mr, input logic mw,
                      input logic br, input logic jo, input logic z);
    opcode = op; RegWrite = rw; MemRead = mr; MemWrite = mw; Branch = br; JumpOut = jo; zero = z;
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1;
    ctrl(3'd0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_retire", retire, 0);

    // R-type add, zero-wait memory
    #10 reset = 1'b1;  // released at t=12, mid-cycle
    ctrl(3'd0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("r_c0_mem_req", mem_req, 1);
    chk("r_c0_ifetch", mem_ifetch, 1);
    chk("r_c0_we", mem_we, 0);
    chk("r_c0_ir_write", ir_write, 1);
    chk("r_c0_pc_inc", pc_inc, 1);
    tick();
    chk("r_c1_state", state, 1);
    chk("r_c1_mem_req", mem_req, 0);
    chk("r_c1_busy", busy, 1);
    tick();
    chk("r_c2_state", state, 2);
    chk("r_c2_retire", retire, 0);
    tick();
    chk("r_c3_state", state, 4);
    chk("r_c3_reg_we", reg_we, 1);
    chk("r_c3_retire", retire, 1);
    tick();
    chk("r_c4_count", instr_count, 1);
    chk("r_c4_mem_req", mem_req, 1);
    chk("r_c4_ifetch", mem_ifetch, 1);

    // LW with two wait cycles in MEMORY
    ctrl(3'd2, 1, 1, 0, 0, 0, 0);
    chk("lw_c0_ir_write", ir_write, 1);
    tick();
    tick();
    chk("lw_c2_state", state, 2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk("lw_mem_state", state, 3);
      chk("lw_mem_req", mem_req, 1);
      chk("lw_mem_we", mem_we, 0);
      chk("lw_mem_ifetch", mem_ifetch, 0);
      chk("lw_mem_retire", retire, 0);
      tick();
    end
    chk("lw_wb_state", state, 4);
    chk("lw_wb_reg_we", reg_we, 1);
    chk("lw_wb_retire", retire, 1);
    tick();
    chk("lw_count", instr_count, 2);
    chk("lw_next_fetch", state, 0);

    // Branches: opcode 4 zero=1 / zero=0, opcode 5 zero=0, opcode 7
    ctrl(3'd4, 0, 0, 0, 1, 0, 1);
    tick(); tick();
    chk("beq_t_pc_load", pc_load, 1);
    chk("beq_t_pc_inc", pc_inc, 0);
    chk("beq_t_retire", retire, 1);
    tick();
    ctrl(3'd4, 0, 0, 0, 1, 0, 0);
    tick(); tick();
    chk("beq_n_pc_load", pc_load, 0);
    chk("beq_n_retire", retire, 1);
    tick();
    chk("beq_count", instr_count, 4);
    ctrl(3'd5, 0, 0, 0, 1, 0, 0);
    tick(); tick();
    chk("bne_pc_load", pc_load, 1);
    chk("bne_reg_we", reg_we, 0);
    tick();
    chk("bne_reg_we_f", reg_we, 0);
    ctrl(3'd7, 0, 0, 0, 1, 1, 1);
    tick(); tick();
    chk("jmp_pc_load", pc_load, 1);
    chk("jmp_reg_we", reg_we, 0);
    chk("jmp_retire", retire, 1);
    tick();
    chk("jmp_count", instr_count, 6);

    // run drops while a fetch is pending
    ctrl(3'd1, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b0;
    #1;
    chk("pend_req0", mem_req, 1);
    tick();
    run = 1'b0;
    #1;
    chk("pend_req_held", mem_req, 1);
    chk("pend_ifetch_held", mem_ifetch, 1);
    chk("pend_state", state, 0);
    mem_ready = 1'b1;
    #1;
    chk("pend_ir_write", ir_write, 1);
    tick(); tick();
    chk("pend_retire", retire, 1);
    tick();
    chk("idle_mem_req", mem_req, 0);
    chk("idle_busy", busy, 0);
    chk("idle_count", instr_count, 7);
    tick();
    chk("idle2_mem_req", mem_req, 0);
    chk("idle2_state", state, 0);
    run = 1'b1;
    #1;
    chk("resume_mem_req", mem_req, 1);

    // Reset asserted in MEMORY of SW
    ctrl(3'd3, 0, 0, 1, 0, 0, 0);
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_mem_state", state, 3);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("sw_rst_mem_req", mem_req, 0);
    chk("sw_rst_state", state, 0);
    chk("sw_rst_count", instr_count, 0);
    chk("sw_rst_retire", retire, 0);
    chk("sw_rst_count_w", instr_count2, 0);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    ctrl(3'd1, 0, 0, 0, 0, 0, 0);

    // Counter wrap on the narrow instance: 8 retires bring 3'b111 back to 0
    for (int n = 0; n < 7; n++) begin
      tick(); tick(); tick();
    end
    chk("wrap_pre", instr_count2, 7);
    tick(); tick();
    chk("wrap_retire", retire2, 1);
    tick();
    chk("wrap_post", instr_count2, 0);
    chk("wrap_wide", instr_count, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
